// File: rtl/cpu_test_busslave_if.sv
// Test-CPU bus handshake bundle: the initiator drives memrq/memwr/addr/busin and
// the responder answers with memack/memdone/busout.
interface cpu_test_busslave_if;
    logic        memrq;
    logic        memwr;
    logic [21:0] addr;
    logic [31:0] busin;
    logic        memack;
    logic        memdone;
    logic [31:0] busout;

    modport master (
        output memrq, memwr, addr, busin,
        input  memack, memdone, busout
    );

    modport slave (
        input  memrq, memwr, addr, busin,
        output memack, memdone, busout
    );
endinterface

// File: rtl/cpu_test_busslave.sv
// Bus responder for the test CPU: word RAM plus an emulated disk-controller register window.
// Define CPU_TEST_BUSSLAVE_RANDLAT_EN to add 0..3 LFSR-driven wait cycles to every request.
module cpu_test_busslave #(
    parameter int MEM_AW           = 8,
    parameter int LATENCY          = 2,
    parameter int DISK_BUSY_CYCLES = 16
) (
    input  logic                clk,
    input  logic                reset,
    cpu_test_busslave_if.slave  busint,
    output logic                disk_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAT,
        S_ACK,
        S_DONE,
        S_RELEASE
    } state_e;

    localparam logic [18:0]       REG_WINDOW = 19'o1737777;
    localparam int                BUSY_W     = $clog2(DISK_BUSY_CYCLES + 1);
    localparam logic [BUSY_W-1:0] BUSY_LOAD  = BUSY_W'(DISK_BUSY_CYCLES);

    state_e            state_q, state_d;
    logic [4:0]        lat_cnt_q, lat_cnt_d;
    logic [21:0]       addr_q, addr_d;
    logic              wr_q, wr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              memack_q, memack_d;
    logic              memdone_q, memdone_d;
    logic [31:0]       busout_q, busout_d;
    logic              ready_q, ready_d;
    logic              disk_busy_q, disk_busy_d;
    logic [BUSY_W-1:0] busy_cnt_q, busy_cnt_d;
    logic [31:0]       cmd_q, cmd_d;
    logic [31:0]       clp_q, clp_d;
    logic [31:0]       da_q, da_d;

    logic [31:0]       ram_q [1 << MEM_AW];
    logic              ram_we;
    logic [4:0]        lat_total;
    logic              is_reg;
    logic [31:0]       reg_rdata;

`ifdef CPU_TEST_BUSSLAVE_RANDLAT_EN
    logic [7:0] lfsr_q, lfsr_d;

    // x^8+x^6+x^5+x^4+1, free-running; the low two bits are the extra wait sampled at acceptance.
    always_comb lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    always_ff @(posedge clk) begin
        if (reset) lfsr_q <= 8'h5A;
        else       lfsr_q <= lfsr_d;
    end

    assign lat_total = 5'(LATENCY) + {3'b000, lfsr_q[1:0]};
`else
    assign lat_total = 5'(LATENCY);
`endif

    assign is_reg = (addr_q[21:3] == REG_WINDOW);

    always_comb begin
        reg_rdata = '0;
        case (addr_q[2:0])
            3'd0:    reg_rdata = {31'b0, ready_q};
            3'd4:    reg_rdata = cmd_q;
            3'd5:    reg_rdata = clp_q;
            3'd6:    reg_rdata = da_q;
            default: reg_rdata = '0;
        endcase
    end

    // NOTE: every signal assigned here gets its default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        lat_cnt_d   = lat_cnt_q;
        addr_d      = addr_q;
        wr_d        = wr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        ready_d     = ready_q;
        disk_busy_d = disk_busy_q;
        busy_cnt_d  = busy_cnt_q;
        cmd_d       = cmd_q;
        clp_d       = clp_q;
        da_d        = da_q;
        ram_we      = 1'b0;
        memack_d    = (state_q == S_ACK);
        memdone_d   = (state_q == S_DONE);
        busout_d    = (state_q == S_DONE) ? rdata_q : '0;

        if (busy_cnt_q != '0) begin
            busy_cnt_d = busy_cnt_q - 1'b1;
            if (busy_cnt_q == BUSY_W'(1)) begin
                ready_d     = 1'b1;
                disk_busy_d = 1'b0;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (busint.memrq) begin
                    addr_d  = busint.addr;
                    wr_d    = busint.memwr;
                    wdata_d = busint.busin;
                    if (lat_total == 5'd1) begin
                        state_d = S_ACK;
                    end else begin
                        lat_cnt_d = lat_total - 5'd1;
                        state_d   = S_LAT;
                    end
                end
            end
            S_LAT: begin
                lat_cnt_d = lat_cnt_q - 5'd1;
                if (lat_cnt_q == 5'd1) state_d = S_ACK;
            end
            S_ACK: begin
                if (wr_q) begin
                    state_d = S_RELEASE;
                    if (is_reg) begin
                        case (addr_q[2:0])
                            3'd4: cmd_d = wdata_q;
                            3'd5: clp_d = wdata_q;
                            3'd6: da_d  = wdata_q;
                            // GO outranks the countdown above, so a retrigger never sets ready.
                            3'd7: begin
                                busy_cnt_d  = BUSY_LOAD;
                                ready_d     = 1'b0;
                                disk_busy_d = 1'b1;
                            end
                            default: ;
                        endcase
                    end else begin
                        ram_we = 1'b1;
                    end
                end else begin
                    state_d = S_DONE;
                    rdata_d = is_reg ? reg_rdata : ram_q[addr_q[MEM_AW-1:0]];
                end
            end
            S_DONE:    state_d = S_RELEASE;
            // The initiator's memrq lags the handshake; waiting here prevents a duplicate access.
            S_RELEASE: if (!busint.memrq) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            lat_cnt_q   <= '0;
            addr_q      <= '0;
            wr_q        <= 1'b0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            memack_q    <= 1'b0;
            memdone_q   <= 1'b0;
            busout_q    <= '0;
            ready_q     <= 1'b1;
            disk_busy_q <= 1'b0;
            busy_cnt_q  <= '0;
            cmd_q       <= '0;
            clp_q       <= '0;
            da_q        <= '0;
        end else begin
            state_q     <= state_d;
            lat_cnt_q   <= lat_cnt_d;
            addr_q      <= addr_d;
            wr_q        <= wr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            memack_q    <= memack_d;
            memdone_q   <= memdone_d;
            busout_q    <= busout_d;
            ready_q     <= ready_d;
            disk_busy_q <= disk_busy_d;
            busy_cnt_q  <= busy_cnt_d;
            cmd_q       <= cmd_d;
            clp_q       <= clp_d;
            da_q        <= da_d;
        end
    end

    // NOTE: the RAM has no reset; its contents survive reset and power up undefined.
    always_ff @(posedge clk) begin
        if (ram_we && !reset) ram_q[addr_q[MEM_AW-1:0]] <= wdata_q;
    end

    assign busint.memack  = memack_q;
    assign busint.memdone = memdone_q;
    assign busint.busout  = busout_q;
    assign disk_busy      = disk_busy_q;

endmodule

// File: tb/tb_cpu_test_busslave.sv
// Self-checking bench for cpu_test_busslave: read data is scoreboarded on memdone,
// handshake timing and disk-controller timing are checked per scenario task.
module tb_cpu_test_busslave;

    localparam int MEM_AW  = 8;
    localparam int LATENCY = 2;
    localparam int BUSY    = 16;
`ifdef CPU_TEST_BUSSLAVE_RANDLAT_EN
    localparam int LAT_MAX = LATENCY + 3;
`else
    localparam int LAT_MAX = LATENCY;
`endif

    localparam logic [21:0] A_STATUS = 22'h3DFFF8;
    localparam logic [21:0] A_RSV2   = 22'h3DFFFA;
    localparam logic [21:0] A_CMD    = 22'h3DFFFC;
    localparam logic [21:0] A_CLP    = 22'h3DFFFD;
    localparam logic [21:0] A_DA     = 22'h3DFFFE;
    localparam logic [21:0] A_GO     = 22'h3DFFFF;

    logic clk = 1'b0;
    logic reset;
    logic disk_busy;

    cpu_test_busslave_if busint ();

    cpu_test_busslave #(
        .MEM_AW           (MEM_AW),
        .LATENCY          (LATENCY),
        .DISK_BUSY_CYCLES (BUSY)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .busint    (busint),
        .disk_busy (disk_busy)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          ack_cnt = 0;
    int          done_cnt = 0;
    int          fall_cnt = 0;
    int          fall_cyc = -1;
    int          rise_cyc = -1;
    int          last_ack_cyc = -1;
    logic        prev_busy = 1'bx;
    logic [31:0] exp_q [$];

    always @(posedge clk) cyc++;

    // Scoreboard and event monitor, sampled 1 time unit after the clock edge.
    always @(posedge clk) begin
        logic [31:0] exp;
        #1;
        if (busint.memack === 1'b1) ack_cnt++;
        if (busint.memdone === 1'b1) begin
            done_cnt++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: memdone with busout=%h, none expected", busint.busout);
            end else begin
                exp = exp_q.pop_front();
                if (busint.busout !== exp) begin
                    bad++;
                    $display("FAIL sb_data: busout=%h expected=%h", busint.busout, exp);
                end
            end
        end
        if (prev_busy === 1'b0 && disk_busy === 1'b1) rise_cyc = cyc;
        if (prev_busy === 1'b1 && disk_busy === 1'b0) begin
            fall_cyc = cyc;
            fall_cnt++;
        end
        prev_busy = disk_busy;
    end

    // Drives one request; request fields are scrambled after acceptance to prove they are latched.
    task automatic bus_access(input logic wr, input logic [21:0] a, input logic [31:0] wd,
                              input int hold, output int lat);
        int acc;
        bit got;
        @(negedge clk);
        busint.memrq = 1'b1;
        busint.memwr = wr;
        busint.addr  = a;
        busint.busin = wd;
        @(posedge clk);
        #1;
        acc = cyc;
        @(negedge clk);
        busint.memwr = ~wr;
        busint.addr  = ~a;
        busint.busin = ~wd;
        got = 1'b0;
        lat = -1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk);
            #1;
            if (busint.memack === 1'b1) begin
                got          = 1'b1;
                lat          = cyc - acc;
                last_ack_cyc = cyc;
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL ack_timeout: addr=%h no memack within 40 cycles", a);
        end else if (!wr) begin
            @(posedge clk);
            #1;
            total++;
            if (busint.memdone !== 1'b1) begin
                bad++;
                $display("FAIL read_done: memdone=%b one cycle after memack, expected 1", busint.memdone);
            end
            @(posedge clk);
            #1;
            total++;
            if (busint.busout !== 32'h0 || busint.memdone !== 1'b0) begin
                bad++;
                $display("FAIL busout_clear: busout=%h memdone=%b after strobe, expected 0/0",
                         busint.busout, busint.memdone);
            end
        end
        repeat (hold) @(posedge clk);
        @(negedge clk);
        busint.memrq = 1'b0;
        busint.memwr = 1'b0;
        busint.addr  = '0;
        busint.busin = '0;
        @(posedge clk);
    endtask

    task automatic do_write(input logic [21:0] a, input logic [31:0] d, output int lat);
        bus_access(1'b1, a, d, 0, lat);
    endtask

    task automatic do_read(input logic [21:0] a, input logic [31:0] exp, output int lat);
        exp_q.push_back(exp);
        bus_access(1'b0, a, 32'h0, 0, lat);
    endtask

    task automatic test_reset();
        int lat;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (busint.memack !== 1'b0) begin bad++; $display("FAIL rst_memack: got %b want 0", busint.memack); end
        total++;
        if (busint.memdone !== 1'b0) begin bad++; $display("FAIL rst_memdone: got %b want 0", busint.memdone); end
        total++;
        if (busint.busout !== 32'h0) begin bad++; $display("FAIL rst_busout: got %h want 0", busint.busout); end
        total++;
        if (disk_busy !== 1'b0) begin bad++; $display("FAIL rst_disk_busy: got %b want 0", disk_busy); end
        @(negedge clk);
        reset = 1'b0;
        do_read(A_STATUS, 32'h1, lat);
    endtask

    task automatic test_write_read();
        int lat;
        do_write(22'h11005, 32'hCAFE0005, lat);
        total++;
        if (lat < LATENCY || lat > LAT_MAX) begin
            bad++;
            $display("FAIL wr_latency: got %0d want %0d..%0d", lat, LATENCY, LAT_MAX);
        end
        do_read(22'h11005, 32'hCAFE0005, lat);
        total++;
        if (lat < LATENCY || lat > LAT_MAX) begin
            bad++;
            $display("FAIL rd_latency: got %0d want %0d..%0d", lat, LATENCY, LAT_MAX);
        end
        do_read(22'h00005, 32'hCAFE0005, lat);
        do_write(22'h000FF, 32'h12345678, lat);
        do_read(22'h3FFFFF, 32'h12345678, lat);
        do_write(22'h3DFFF7, 32'h0F0F00F7, lat);
        do_read(22'h000F7, 32'h0F0F00F7, lat);
        // Reserved and GO offsets read zero; a reserved write must not reach RAM.
        do_write(22'h000FA, 32'hAAAA00FA, lat);
        do_write(A_RSV2, 32'hBBBB0002, lat);
        do_read(A_RSV2, 32'h0, lat);
        do_read(22'h000FA, 32'hAAAA00FA, lat);
        do_read(A_GO, 32'h0, lat);
    endtask

    task automatic test_held_memrq();
        int lat, a0, d0;
        do_write(22'h000DF, 32'h5555AAAA, lat);
        a0 = ack_cnt;
        bus_access(1'b1, 22'h00020, 32'h0BADF00D, 3, lat);
        total++;
        if (ack_cnt - a0 !== 1) begin
            bad++;
            $display("FAIL held_wr_acks: got %0d memacks want 1", ack_cnt - a0);
        end
        a0 = ack_cnt;
        d0 = done_cnt;
        exp_q.push_back(32'h0BADF00D);
        bus_access(1'b0, 22'h00020, 32'h0, 3, lat);
        total++;
        if (ack_cnt - a0 !== 1 || done_cnt - d0 !== 1) begin
            bad++;
            $display("FAIL held_rd_pulses: got acks=%0d dones=%0d want 1/1", ack_cnt - a0, done_cnt - d0);
        end
        do_read(22'h000DF, 32'h5555AAAA, lat);
    endtask

    task automatic test_disk();
        int lat, tg, f0;
        do_write(A_DA, 32'h0, lat);
        do_write(A_CLP, 32'h10001, lat);
        do_write(A_CMD, 32'h9, lat);
        f0 = fall_cnt;
        do_write(A_GO, 32'h0, lat);
        tg = last_ack_cyc;
        total++;
        if (rise_cyc !== tg) begin
            bad++;
            $display("FAIL disk_busy_rise: rose at cycle %0d want %0d", rise_cyc, tg);
        end
        do_read(A_STATUS, 32'h0, lat);
        for (int i = 0; i < 60 && fall_cnt == f0; i++) begin
            @(posedge clk);
            #2;
        end
        total++;
        if (fall_cnt - f0 !== 1 || fall_cyc - tg !== BUSY) begin
            bad++;
            $display("FAIL disk_ready_time: falls=%0d at +%0d want 1 at +%0d",
                     fall_cnt - f0, fall_cyc - tg, BUSY);
        end
        do_read(A_STATUS, 32'h1, lat);
        do_read(A_CMD, 32'h9, lat);
        do_read(A_CLP, 32'h10001, lat);
        do_read(A_DA, 32'h0, lat);
    endtask

    task automatic test_go_while_busy();
        int lat, t1, t2, f0;
        f0 = fall_cnt;
        do_write(A_GO, 32'h0, lat);
        t1 = last_ack_cyc;
        @(posedge clk);
        do_write(A_GO, 32'h0, lat);
        t2 = last_ack_cyc;
        for (int i = 0; i < 60 && fall_cnt == f0; i++) begin
            @(posedge clk);
            #2;
        end
        total++;
        if (fall_cnt - f0 !== 1 || fall_cyc - t2 !== BUSY) begin
            bad++;
            $display("FAIL go_reload: falls=%0d ready at +%0d from 2nd GO (+%0d from 1st) want +%0d",
                     fall_cnt - f0, fall_cyc - t2, fall_cyc - t1, BUSY);
        end
        do_read(A_STATUS, 32'h1, lat);
    endtask

    task automatic test_reset_mid_write();
        int lat, a0;
        do_write(22'h00033, 32'h600D0033, lat);
        do_write(A_GO, 32'h0, lat);
        a0 = ack_cnt;
        @(negedge clk);
        busint.memrq = 1'b1;
        busint.memwr = 1'b1;
        busint.addr  = 22'h00033;
        busint.busin = 32'hDEADBEEF;
        @(posedge clk);
        @(negedge clk);
        reset        = 1'b1;
        busint.memrq = 1'b0;
        busint.memwr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (ack_cnt !== a0) begin bad++; $display("FAIL mid_rst_ack: got %0d memacks want 0", ack_cnt - a0); end
        total++;
        if (busint.memdone !== 1'b0 || busint.busout !== 32'h0) begin
            bad++;
            $display("FAIL mid_rst_outputs: memdone=%b busout=%h want 0/0", busint.memdone, busint.busout);
        end
        total++;
        if (disk_busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy: got %b want 0", disk_busy); end
        @(negedge clk);
        reset = 1'b0;
        do_read(A_STATUS, 32'h1, lat);
        do_read(22'h00033, 32'h600D0033, lat);
    endtask

    task automatic test_latency_spread();
        int  lat;
        bit  seen [8];
        int  distinct;
        for (int i = 0; i < 8; i++) seen[i] = 1'b0;
        for (int i = 0; i < 64; i++) begin
            do_read(22'h11005, 32'hCAFE0005, lat);
            total++;
            if (lat < LATENCY || lat > LAT_MAX) begin
                bad++;
                $display("FAIL spread_latency: read %0d got %0d want %0d..%0d", i, lat, LATENCY, LAT_MAX);
            end else begin
                seen[lat] = 1'b1;
            end
        end
        distinct = 0;
        for (int i = 0; i < 8; i++) if (seen[i]) distinct++;
`ifdef CPU_TEST_BUSSLAVE_RANDLAT_EN
        total++;
        if (distinct < 2) begin bad++; $display("FAIL spread_distinct: got %0d latencies want >1", distinct); end
`else
        total++;
        if (distinct != 1) begin bad++; $display("FAIL spread_fixed: got %0d latencies want 1", distinct); end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        busint.memrq = 1'b0;
        busint.memwr = 1'b0;
        busint.addr  = '0;
        busint.busin = '0;
        test_reset();
        test_write_read();
        test_held_memrq();
        test_disk();
        test_go_while_busy();
        test_reset_mid_write();
        test_latency_spread();
        repeat (3) @(posedge clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: %0d reads never completed, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
